// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, cause codes,
// mstatus/mie bit positions, FSM state encoding and the mtval source selector.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [3:0] CAUSE_INST_ADDR_MIS = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL       = 4'd2;
  localparam logic [3:0] CAUSE_BREAK         = 4'd3;
  localparam logic [3:0] CAUSE_LD_ADDR_MIS   = 4'd4;
  localparam logic [3:0] CAUSE_ST_ADDR_MIS   = 4'd6;
  localparam logic [3:0] CAUSE_ECALL         = 4'd11;
  localparam logic [3:0] CAUSE_MSI           = 4'd3;
  localparam logic [3:0] CAUSE_MTI           = 4'd7;
  localparam logic [3:0] CAUSE_MEI           = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_W_MEPC        = 3'd1,
    ST_W_MCAUSE      = 3'd2,
    ST_W_MTVAL       = 3'd3,
    ST_W_MSTATUS     = 3'd4,
    ST_W_MSTATUS_RET = 3'd5,
    ST_REDIRECT      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    TVAL_ZERO = 2'd0,
    TVAL_PC   = 2'd1,
    TVAL_INST = 2'd2,
    TVAL_ADDR = 2'd3
  } tval_sel_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of the write-back, interrupt, CSR and pipeline-control signals of
// the trap sequencer. master = trap_ctrl side, slave = surrounding pipeline.
interface trap_ctrl_if #(parameter int XLEN = 32);

  logic            wb_valid_i;
  logic [XLEN-1:0] wb_pc_i;
  logic [31:0]     wb_inst_i;
  logic [XLEN-1:0] wb_mem_addr_i;
  logic            e_inst_addr_mis_i;
  logic            e_illegal_inst_i;
  logic            e_break_i;
  logic            e_ld_addr_mis_i;
  logic            e_st_addr_mis_i;
  logic            e_ecall_i;
  logic            is_mret_i;
  logic            xint_meip_i;
  logic            xint_mtip_i;
  logic            xint_msip_i;
  logic [XLEN-1:0] mstatus_i;
  logic [XLEN-1:0] mie_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic            csr_we_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            stall_o;
  logic            flush_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            busy_o;

  modport master (
    input  wb_valid_i, wb_pc_i, wb_inst_i, wb_mem_addr_i,
    input  e_inst_addr_mis_i, e_illegal_inst_i, e_break_i,
    input  e_ld_addr_mis_i, e_st_addr_mis_i, e_ecall_i, is_mret_i,
    input  xint_meip_i, xint_mtip_i, xint_msip_i,
    input  mstatus_i, mie_i, mtvec_i, mepc_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o,
    output stall_o, flush_o, redirect_o, redirect_pc_o, busy_o
  );

  modport slave (
    output wb_valid_i, wb_pc_i, wb_inst_i, wb_mem_addr_i,
    output e_inst_addr_mis_i, e_illegal_inst_i, e_break_i,
    output e_ld_addr_mis_i, e_st_addr_mis_i, e_ecall_i, is_mret_i,
    output xint_meip_i, xint_mtip_i, xint_msip_i,
    output mstatus_i, mie_i, mtvec_i, mepc_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o,
    input  stall_o, flush_o, redirect_o, redirect_pc_o, busy_o
  );

endinterface

// File: rtl/trap_prio_enc.sv
// Trap priority encoder: picks the highest-priority exception, or failing
// that the highest-priority enabled interrupt, and reports its cause code and
// which value should land in mtval.
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic      i_inst_addr_mis,
  input  logic      i_illegal,
  input  logic      i_break,
  input  logic      i_ld_mis,
  input  logic      i_st_mis,
  input  logic      i_ecall,
  input  logic      i_int_en,
  input  logic      i_meip,
  input  logic      i_mtip,
  input  logic      i_msip,
  input  logic      i_meie,
  input  logic      i_mtie,
  input  logic      i_msie,
  output logic      o_take,
  output logic      o_is_int,
  output logic [3:0] o_cause,
  output tval_sel_e o_tval_sel
);

  // Fixed-priority chain: exceptions first, then meip > msip > mtip.
  always_comb begin
    o_take     = 1'b1;
    o_is_int   = 1'b0;
    o_cause    = 4'd0;
    o_tval_sel = TVAL_ZERO;
    if (i_inst_addr_mis) begin
      o_cause    = CAUSE_INST_ADDR_MIS;
      o_tval_sel = TVAL_PC;
    end else if (i_illegal) begin
      o_cause    = CAUSE_ILLEGAL;
      o_tval_sel = TVAL_INST;
    end else if (i_break) begin
      o_cause    = CAUSE_BREAK;
    end else if (i_ld_mis) begin
      o_cause    = CAUSE_LD_ADDR_MIS;
      o_tval_sel = TVAL_ADDR;
    end else if (i_st_mis) begin
      o_cause    = CAUSE_ST_ADDR_MIS;
      o_tval_sel = TVAL_ADDR;
    end else if (i_ecall) begin
      o_cause    = CAUSE_ECALL;
    end else if (i_int_en && i_meip && i_meie) begin
      o_is_int   = 1'b1;
      o_cause    = CAUSE_MEI;
    end else if (i_int_en && i_msip && i_msie) begin
      o_is_int   = 1'b1;
      o_cause    = CAUSE_MSI;
    end else if (i_int_en && i_mtip && i_mtie) begin
      o_is_int   = 1'b1;
      o_cause    = CAUSE_MTI;
    end else begin
      o_take     = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Multi-cycle trap sequencer beside write-back. Captures a trap or MRET in
// IDLE, then stalls/flushes the pipeline while writing mepc, mcause, mtval and
// mstatus (or just mstatus for MRET) one per cycle, and finishes with a
// one-cycle PC redirect.
// Optional build macro TRAP_VECTORED_EN: interrupts with mtvec mode 2'b01
// jump to base + 4*cause; without it every trap goes to the mtvec base.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MTVEC_ALIGN = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  trap_ctrl_if.master bus
);

  localparam logic [XLEN-1:0] BASE_MASK = {XLEN{1'b1}} << MTVEC_ALIGN;

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_target;

  logic            w_take;
  logic            w_is_int;
  logic [3:0]      w_code;
  tval_sel_e       w_tval_sel;
  logic            w_trap_go;
  logic            w_ret_go;
  logic [XLEN-1:0] w_tval;
  logic [XLEN-1:0] w_ms_trap;
  logic [XLEN-1:0] w_ms_ret;
  logic [XLEN-1:0] w_trap_target;

  trap_prio_enc u_prio (
    .i_inst_addr_mis (bus.e_inst_addr_mis_i),
    .i_illegal       (bus.e_illegal_inst_i),
    .i_break         (bus.e_break_i),
    .i_ld_mis        (bus.e_ld_addr_mis_i),
    .i_st_mis        (bus.e_st_addr_mis_i),
    .i_ecall         (bus.e_ecall_i),
    .i_int_en        (bus.mstatus_i[MSTATUS_MIE]),
    .i_meip          (bus.xint_meip_i),
    .i_mtip          (bus.xint_mtip_i),
    .i_msip          (bus.xint_msip_i),
    .i_meie          (bus.mie_i[MIE_MEIE]),
    .i_mtie          (bus.mie_i[MIE_MTIE]),
    .i_msie          (bus.mie_i[MIE_MSIE]),
    .o_take          (w_take),
    .o_is_int        (w_is_int),
    .o_cause         (w_code),
    .o_tval_sel      (w_tval_sel)
  );

  // Decide what starts in IDLE: exceptions beat MRET, MRET beats interrupts;
  // also build the captured tval, both mstatus images and the trap target.
  always_comb begin
    w_trap_go = 1'b0;
    w_ret_go  = 1'b0;
    if (r_state == ST_IDLE && bus.wb_valid_i) begin
      if (w_take && !w_is_int) begin
        w_trap_go = 1'b1;
      end else if (bus.is_mret_i) begin
        w_ret_go  = 1'b1;
      end else if (w_take) begin
        w_trap_go = 1'b1;
      end
    end

    case (w_tval_sel)
      TVAL_PC:   w_tval = bus.wb_pc_i;
      TVAL_INST: w_tval = XLEN'(bus.wb_inst_i);
      TVAL_ADDR: w_tval = bus.wb_mem_addr_i;
      default:   w_tval = '0;
    endcase

    w_ms_trap = bus.mstatus_i;
    w_ms_trap[MSTATUS_MPIE] = bus.mstatus_i[MSTATUS_MIE];
    w_ms_trap[MSTATUS_MIE]  = 1'b0;
    w_ms_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    w_ms_ret = bus.mstatus_i;
    w_ms_ret[MSTATUS_MIE]  = bus.mstatus_i[MSTATUS_MPIE];
    w_ms_ret[MSTATUS_MPIE] = 1'b1;
    w_ms_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;

    w_trap_target = bus.mtvec_i & BASE_MASK;
`ifdef TRAP_VECTORED_EN
    if (w_is_int && bus.mtvec_i[1:0] == 2'b01) begin
      w_trap_target = (bus.mtvec_i & BASE_MASK) + XLEN'({w_code, 2'b00});
    end
`endif
  end

  // Latch everything the sequence needs at the start so later input changes
  // cannot disturb the writes or the redirect target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cause   <= '0;
      r_epc     <= '0;
      r_tval    <= '0;
      r_mstatus <= '0;
      r_target  <= '0;
    end else if (w_trap_go) begin
      r_cause   <= {w_is_int, {(XLEN-5){1'b0}}, w_code};
      r_epc     <= bus.wb_pc_i;
      r_tval    <= w_tval;
      r_mstatus <= w_ms_trap;
      r_target  <= w_trap_target;
    end else if (w_ret_go) begin
      r_mstatus <= w_ms_ret;
      r_target  <= bus.mepc_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing and state-decoded outputs; CSR port is zero
  // whenever no write is being issued.
  always_comb begin
    w_next            = r_state;
    bus.csr_we_o      = 1'b0;
    bus.csr_waddr_o   = '0;
    bus.csr_wdata_o   = '0;
    bus.redirect_o    = 1'b0;
    bus.redirect_pc_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_trap_go)     w_next = ST_W_MEPC;
        else if (w_ret_go) w_next = ST_W_MSTATUS_RET;
      end
      ST_W_MEPC: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MEPC;
        bus.csr_wdata_o = r_epc;
        w_next          = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MCAUSE;
        bus.csr_wdata_o = r_cause;
        w_next          = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MTVAL;
        bus.csr_wdata_o = r_tval;
        w_next          = ST_W_MSTATUS;
      end
      ST_W_MSTATUS, ST_W_MSTATUS_RET: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MSTATUS;
        bus.csr_wdata_o = r_mstatus;
        w_next          = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        bus.redirect_o    = 1'b1;
        bus.redirect_pc_o = r_target;
        w_next            = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.busy_o  = (r_state != ST_IDLE);
  assign bus.stall_o = (r_state != ST_IDLE);
  assign bus.flush_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: reset state, full trap sequences for
// several exception/interrupt mixes, MRET, masked/invalid cases and a reset
// arriving in the middle of a sequence.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(32)) bus ();

  trap_ctrl #(.XLEN(32), .MTVEC_ALIGN(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // exc = {inst_addr_mis, illegal, break, ld_mis, st_mis, ecall}
  // irq = {meip, mtip, msip}
  typedef struct {
    string       name;
    logic [31:0] pc, inst, addr;
    logic [5:0]  exc;
    logic        mret;
    logic [2:0]  irq;
    logic [31:0] mstatus, mie, mtvec, mepc;
    logic [31:0] eCause, eTval, eMs, eTarget;
  } vec_t;

  function automatic vec_t mk(string n, logic [31:0] pc, logic [31:0] inst,
                              logic [31:0] addr, logic [5:0] exc, logic mret,
                              logic [2:0] irq, logic [31:0] ms, logic [31:0] mie,
                              logic [31:0] mtvec, logic [31:0] mepc,
                              logic [31:0] c, logic [31:0] tv,
                              logic [31:0] ems, logic [31:0] tgt);
    vec_t v;
    v.name = n; v.pc = pc; v.inst = inst; v.addr = addr; v.exc = exc;
    v.mret = mret; v.irq = irq; v.mstatus = ms; v.mie = mie; v.mtvec = mtvec;
    v.mepc = mepc; v.eCause = c; v.eTval = tv; v.eMs = ems; v.eTarget = tgt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic valid);
    bus.wb_valid_i        = valid;
    bus.wb_pc_i           = v.pc;
    bus.wb_inst_i         = v.inst;
    bus.wb_mem_addr_i     = v.addr;
    bus.e_inst_addr_mis_i = v.exc[5];
    bus.e_illegal_inst_i  = v.exc[4];
    bus.e_break_i         = v.exc[3];
    bus.e_ld_addr_mis_i   = v.exc[2];
    bus.e_st_addr_mis_i   = v.exc[1];
    bus.e_ecall_i         = v.exc[0];
    bus.is_mret_i         = v.mret;
    bus.xint_meip_i       = v.irq[2];
    bus.xint_mtip_i       = v.irq[1];
    bus.xint_msip_i       = v.irq[0];
    bus.mstatus_i         = v.mstatus;
    bus.mie_i             = v.mie;
    bus.mtvec_i           = v.mtvec;
    bus.mepc_i            = v.mepc;
  endtask

  task automatic clearInputs();
    vec_t z;
    z = mk("idle", 0, 0, 0, 6'b0, 1'b0, 3'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(z, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] w;
    w = {bus.csr_we_o, bus.redirect_o, bus.busy_o, bus.stall_o, bus.flush_o,
         27'd0};
    checks++;
    if (w !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %h want 0", w);
    end
    checks++;
    if (bus.csr_waddr_o !== 12'd0 || bus.csr_wdata_o !== 32'd0 ||
        bus.redirect_pc_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: waddr %h wdata %h rpc %h want 0",
               bus.csr_waddr_o, bus.csr_wdata_o, bus.redirect_pc_o);
    end
  endtask

  task automatic test_trap_sequences();
    vec_t vs[$];
    logic [31:0] vecTgt, vecTgt2;
`ifdef TRAP_VECTORED_EN
    vecTgt  = 32'h22C;
    vecTgt2 = 32'h20C;
`else
    vecTgt  = 32'h200;
    vecTgt2 = 32'h200;
`endif
    vs.push_back(mk("illegal", 32'h100, 32'hFFFFFFFF, 0, 6'b010000, 0, 3'b000,
                    32'h0, 32'h0, 32'h200, 0, 32'd2, 32'hFFFFFFFF, 32'h1800, 32'h200));
    vs.push_back(mk("ldmis_ecall", 32'h104, 32'h13, 32'h1003, 6'b000101, 0, 3'b000,
                    32'h0, 32'h0, 32'h200, 0, 32'd4, 32'h1003, 32'h1800, 32'h200));
    vs.push_back(mk("mtip", 32'h108, 32'h13, 0, 6'b000000, 0, 3'b010,
                    32'h8, 32'h80, 32'h200, 0, 32'h80000007, 0, 32'h1880, 32'h200));
    vs.push_back(mk("iam_mret", 32'h10C, 32'h13, 0, 6'b100000, 1, 3'b000,
                    32'h1880, 32'h0, 32'h200, 32'h44, 32'd0, 32'h10C, 32'h1800, 32'h200));
    vs.push_back(mk("meip_vec", 32'h110, 32'h13, 0, 6'b000000, 0, 3'b100,
                    32'h8, 32'h800, 32'h201, 0, 32'h8000000B, 0, 32'h1880, vecTgt));
    vs.push_back(mk("brk_stmis", 32'h114, 32'h13, 32'h2000, 6'b001010, 0, 3'b110,
                    32'h8, 32'h880, 32'h201, 0, 32'd3, 0, 32'h1880, 32'h200));
    vs.push_back(mk("msip_mtip", 32'h118, 32'h13, 0, 6'b000000, 0, 3'b011,
                    32'h8, 32'h88, 32'h201, 0, 32'h80000003, 0, 32'h1880, vecTgt2));
    foreach (vs[i]) begin
      vec_t v;
      v = vs[i];
      applyStimulus(v, 1'b1);
      @(posedge clk);
      #1 clearInputs();
      for (int k = 1; k <= 6; k++) begin
        logic        eWe, eRed, eBusy;
        logic [11:0] eAddr;
        logic [31:0] eData, ePc;
        @(negedge clk);
        eWe = (k <= 4); eRed = (k == 5); eBusy = (k <= 5);
        ePc = (k == 5) ? v.eTarget : 32'd0;
        case (k)
          1: begin eAddr = 12'h341; eData = v.pc;     end
          2: begin eAddr = 12'h342; eData = v.eCause; end
          3: begin eAddr = 12'h343; eData = v.eTval;  end
          4: begin eAddr = 12'h300; eData = v.eMs;    end
          default: begin eAddr = 12'h000; eData = 32'd0; end
        endcase
        checks++;
        if (bus.csr_we_o !== eWe) begin
          errors++;
          $display("[TB] FAIL %s c%0d we: got %b want %b", v.name, k, bus.csr_we_o, eWe);
        end
        checks++;
        if (bus.csr_waddr_o !== eAddr) begin
          errors++;
          $display("[TB] FAIL %s c%0d waddr: got %h want %h", v.name, k, bus.csr_waddr_o, eAddr);
        end
        checks++;
        if (bus.csr_wdata_o !== eData) begin
          errors++;
          $display("[TB] FAIL %s c%0d wdata: got %h want %h", v.name, k, bus.csr_wdata_o, eData);
        end
        checks++;
        if (bus.redirect_o !== eRed || bus.redirect_pc_o !== ePc) begin
          errors++;
          $display("[TB] FAIL %s c%0d redirect: got %b/%h want %b/%h", v.name, k,
                   bus.redirect_o, bus.redirect_pc_o, eRed, ePc);
        end
        checks++;
        if (bus.busy_o !== eBusy || bus.stall_o !== eBusy || bus.flush_o !== eBusy) begin
          errors++;
          $display("[TB] FAIL %s c%0d busy/stall/flush: got %b%b%b want %b", v.name, k,
                   bus.busy_o, bus.stall_o, bus.flush_o, eBusy);
        end
      end
    end
  endtask

  task automatic test_mret();
    vec_t vs[$];
    vs.push_back(mk("mret", 32'h200, 32'h30200073, 0, 6'b0, 1, 3'b000,
                    32'h1880, 32'h0, 32'h200, 32'h44, 0, 0, 32'h88, 32'h44));
    vs.push_back(mk("mret_over_int", 32'h204, 32'h30200073, 0, 6'b0, 1, 3'b010,
                    32'h1888, 32'h80, 32'h200, 32'h48, 0, 0, 32'h88, 32'h48));
    foreach (vs[i]) begin
      vec_t v;
      v = vs[i];
      applyStimulus(v, 1'b1);
      @(posedge clk);
      #1 clearInputs();
      for (int k = 1; k <= 3; k++) begin
        logic        eWe, eRed, eBusy;
        logic [11:0] eAddr;
        logic [31:0] eData, ePc;
        @(negedge clk);
        eWe = (k == 1); eRed = (k == 2); eBusy = (k <= 2);
        eAddr = (k == 1) ? 12'h300 : 12'h000;
        eData = (k == 1) ? v.eMs : 32'd0;
        ePc   = (k == 2) ? v.eTarget : 32'd0;
        checks++;
        if (bus.csr_we_o !== eWe || bus.csr_waddr_o !== eAddr || bus.csr_wdata_o !== eData) begin
          errors++;
          $display("[TB] FAIL %s c%0d csr: got %b/%h/%h want %b/%h/%h", v.name, k,
                   bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, eWe, eAddr, eData);
        end
        checks++;
        if (bus.redirect_o !== eRed || bus.redirect_pc_o !== ePc) begin
          errors++;
          $display("[TB] FAIL %s c%0d redirect: got %b/%h want %b/%h", v.name, k,
                   bus.redirect_o, bus.redirect_pc_o, eRed, ePc);
        end
        checks++;
        if (bus.busy_o !== eBusy) begin
          errors++;
          $display("[TB] FAIL %s c%0d busy: got %b want %b", v.name, k, bus.busy_o, eBusy);
        end
      end
    end
  endtask

  task automatic test_no_trap();
    vec_t vs[$];
    logic valid[$];
    vs.push_back(mk("int_masked", 32'h300, 32'h13, 0, 6'b0, 0, 3'b111,
                    32'h0, 32'h888, 32'h200, 0, 0, 0, 0, 0));
    valid.push_back(1'b1);
    vs.push_back(mk("wb_invalid", 32'h304, 32'hFFFFFFFF, 0, 6'b111111, 1, 3'b111,
                    32'h8, 32'h888, 32'h200, 0, 0, 0, 0, 0));
    valid.push_back(1'b0);
    foreach (vs[i]) begin
      applyStimulus(vs[i], valid[i]);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.csr_we_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s c%0d idle: got busy %b we %b red %b want 000", vs[i].name, k,
                   bus.busy_o, bus.csr_we_o, bus.redirect_o);
        end
      end
      clearInputs();
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    v = mk("rst_mid", 32'h100, 32'hFFFFFFFF, 0, 6'b010000, 0, 3'b000,
           32'h0, 32'h0, 32'h200, 0, 0, 0, 0, 0);
    applyStimulus(v, 1'b1);
    @(posedge clk);
    #1 clearInputs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h342) begin
      errors++;
      $display("[TB] FAIL rst_mid pre: got we %b addr %h want 1/342", bus.csr_we_o, bus.csr_waddr_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.csr_we_o !== 1'b0 || bus.csr_waddr_o !== 12'd0 || bus.csr_wdata_o !== 32'd0 ||
        bus.redirect_o !== 1'b0 || bus.redirect_pc_o !== 32'd0 || bus.busy_o !== 1'b0 ||
        bus.stall_o !== 1'b0 || bus.flush_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid async: got we %b addr %h data %h red %b busy %b want all 0",
               bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.redirect_o, bus.busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.csr_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_mid after c%0d: got we %b busy %b red %b want 000", k,
                 bus.csr_we_o, bus.busy_o, bus.redirect_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_trap_sequences();
    test_mret();
    test_no_trap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
